// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO write-port sequencer: MTHI/MTLO, fixed-latency multiply and 32-step restoring divide.
// Define HILO_MADD_EN to add MADD/MADDU/MSUB/MSUBU (accumulate into the current HI/LO value).
module hilo_muldiv_ctrl #(
  parameter int unsigned MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic [63:0] hilo_cur,
  input  logic        flush,
  output logic        stall_o,
  output logic        hilo_wen,
  output logic [63:0] hilo_wdata
);

  localparam logic [3:0] OpMult  = 4'd1;
  localparam logic [3:0] OpMultu = 4'd2;
  localparam logic [3:0] OpDiv   = 4'd3;
  localparam logic [3:0] OpDivu  = 4'd4;
  localparam logic [3:0] OpMthi  = 4'd5;
  localparam logic [3:0] OpMtlo  = 4'd6;
`ifdef HILO_MADD_EN
  localparam logic [3:0] OpMadd  = 4'd7;
  localparam logic [3:0] OpMaddu = 4'd8;
  localparam logic [3:0] OpMsub  = 4'd9;
  localparam logic [3:0] OpMsubu = 4'd10;
`endif

  localparam logic [4:0] MulLast = 5'(MUL_LAT - 1);
  localparam logic [4:0] DivLast = 5'd31;

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  state_e      state_q;
  logic [4:0]  cnt_q;
  logic [3:0]  op_q;
  logic [31:0] opa_q;
  logic [31:0] opb_q;
  logic [31:0] rem_q;
  logic [31:0] quo_q;
  logic [63:0] prod_q;

  logic        is_mul;
  logic        is_div;
  logic [31:0] a_in_mag;
  logic        sgn_q;

  // Incoming-op decode and signedness of the latched op.
  always_comb begin
    is_mul = (op == OpMult) || (op == OpMultu);
    sgn_q  = (op_q == OpMult) || (op_q == OpDiv);
`ifdef HILO_MADD_EN
    is_mul = is_mul || (op == OpMadd) || (op == OpMaddu) || (op == OpMsub) || (op == OpMsubu);
    sgn_q  = sgn_q || (op_q == OpMadd) || (op_q == OpMsub);
`endif
    is_div   = (op == OpDiv) || (op == OpDivu);
    a_in_mag = ((op == OpDiv) && src_a[31]) ? (32'd0 - src_a) : src_a;
  end

  // Sign-extending to 64 bits makes one unsigned multiplier serve both signednesses.
  logic [63:0] ext_a;
  logic [63:0] ext_b;
  logic [63:0] product;

  always_comb begin
    ext_a   = {{32{sgn_q & opa_q[31]}}, opa_q};
    ext_b   = {{32{sgn_q & opb_q[31]}}, opb_q};
    product = ext_a * ext_b;
  end

  logic [31:0] dvs;
  logic [32:0] rem_sh;
  logic        rem_ge;
  logic [31:0] rem_nxt;
  logic [31:0] quo_nxt;
  logic [31:0] q_fix;
  logic [31:0] r_fix;

  // One restoring-division step; a zero divisor naturally yields all-ones / dividend.
  always_comb begin
    dvs     = (sgn_q && opb_q[31]) ? (32'd0 - opb_q) : opb_q;
    rem_sh  = {rem_q, quo_q[31]};
    rem_ge  = rem_sh >= {1'b0, dvs};
    rem_nxt = rem_ge ? (rem_sh[31:0] - dvs) : rem_sh[31:0];
    quo_nxt = {quo_q[30:0], rem_ge};
    q_fix   = (sgn_q && (opa_q[31] ^ opb_q[31])) ? (32'd0 - quo_q) : quo_q;
    r_fix   = (sgn_q && opa_q[31]) ? (32'd0 - rem_q) : rem_q;
  end

  logic [63:0] done_data;

  always_comb begin
    done_data = prod_q;
    case (op_q)
      OpDiv, OpDivu:   done_data = {r_fix, q_fix};
`ifdef HILO_MADD_EN
      OpMadd, OpMaddu: done_data = hilo_cur + prod_q;
      OpMsub, OpMsubu: done_data = hilo_cur - prod_q;
`endif
      default:         done_data = prod_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      prod_q  <= '0;
    end else if (flush) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start && is_mul) begin
            op_q    <= op;
            opa_q   <= src_a;
            opb_q   <= src_b;
            cnt_q   <= '0;
            state_q <= StMul;
          end else if (start && is_div) begin
            op_q    <= op;
            opa_q   <= src_a;
            opb_q   <= src_b;
            quo_q   <= a_in_mag;
            rem_q   <= '0;
            cnt_q   <= '0;
            state_q <= StDiv;
          end
        end
        StMul: begin
          prod_q <= product;
          cnt_q  <= cnt_q + 5'd1;
          if (cnt_q == MulLast) state_q <= StDone;
        end
        StDiv: begin
          rem_q <= rem_nxt;
          quo_q <= quo_nxt;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == DivLast) state_q <= StDone;
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Write port and stall are combinational so MTHI/MTLO commit in their own cycle.
  always_comb begin
    hilo_wen   = 1'b0;
    hilo_wdata = '0;
    case (state_q)
      StIdle: begin
        if (start && (op == OpMthi)) begin
          hilo_wen   = 1'b1;
          hilo_wdata = {src_a, hilo_cur[31:0]};
        end else if (start && (op == OpMtlo)) begin
          hilo_wen   = 1'b1;
          hilo_wdata = {hilo_cur[63:32], src_a};
        end
      end
      StDone: begin
        hilo_wen   = 1'b1;
        hilo_wdata = done_data;
      end
      default: ;
    endcase
    if (flush) hilo_wen = 1'b0;
    stall_o = !flush && (((state_q == StIdle) && start && (is_mul || is_div)) ||
                         (state_q == StMul) || (state_q == StDiv));
  end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Scoreboard bench for hilo_muldiv_ctrl: directed cases, then randomized ops with random flushes.
module tb_hilo_muldiv_ctrl;

  localparam int MulLat = 2;

  logic        clk;
  logic        rst;
  logic        start;
  logic [3:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [63:0] hilo_cur;
  logic        flush;
  logic        stall_o;
  logic        hilo_wen;
  logic [63:0] hilo_wdata;

  hilo_muldiv_ctrl #(.MUL_LAT(MulLat)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .op         (op),
    .src_a      (src_a),
    .src_b      (src_b),
    .hilo_cur   (hilo_cur),
    .flush      (flush),
    .stall_o    (stall_o),
    .hilo_wen   (hilo_wen),
    .hilo_wdata (hilo_wdata)
  );

  typedef struct {
    int unsigned cyc;
    logic [63:0] data;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #10000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // Reference model: class 0 none, 1 move, 2 multiply, 3 divide.
  task automatic model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] h, output int cls, output logic [63:0] d);
    longint          sp;
    longint unsigned up;
    int              sa;
    int              sbv;
    logic [31:0]     q;
    logic [31:0]     r;
    sa  = $signed(a);
    sbv = $signed(b);
    sp  = longint'(sa) * longint'(sbv);
    up  = {32'd0, a} * {32'd0, b};
    cls = 0;
    d   = '0;
    case (o)
      4'd1: begin cls = 2; d = sp; end
      4'd2: begin cls = 2; d = up; end
      4'd3: begin
        cls = 3;
        if (b == 0) begin
          q = (sa < 0) ? 32'd1 : 32'hFFFF_FFFF;
          r = a;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          q = 32'h8000_0000;
          r = 32'd0;
        end else begin
          q = sa / sbv;
          r = sa % sbv;
        end
        d = {r, q};
      end
      4'd4: begin
        cls = 3;
        if (b == 0) begin
          q = 32'hFFFF_FFFF;
          r = a;
        end else begin
          q = a / b;
          r = a % b;
        end
        d = {r, q};
      end
      4'd5: begin cls = 1; d = {a, h[31:0]}; end
      4'd6: begin cls = 1; d = {h[63:32], a}; end
`ifdef HILO_MADD_EN
      4'd7:  begin cls = 2; d = h + sp; end
      4'd8:  begin cls = 2; d = h + up; end
      4'd9:  begin cls = 2; d = h - sp; end
      4'd10: begin cls = 2; d = h - up; end
`endif
      default: cls = 0;
    endcase
  endtask

  // fm: -1 no flush, -2 random flush, >=0 flush at that cycle offset from start.
  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       input int fm);
    int          cls;
    int          lat;
    int          f;
    int          k;
    logic [63:0] d;
    bit          lng;
    bit          exp_st;
    bit          wr;
    model(o, a, b, hilo_cur, cls, d);
    lat = (cls == 2) ? MulLat + 1 : (cls == 3) ? 33 : 0;
    lng = (cls >= 2);
    if (fm == -2) f = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, lat)) : -1;
    else f = fm;
    wr = (cls != 0) && (f < 0 || f > lat);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    src_a = a;
    src_b = b;
    if (wr) sb_q.push_back('{cyc + lat, d});
    k = 0;
    while (1) begin
      flush = (k == f);
      #1;
      exp_st = lng && (k < lat) && !(f >= 0 && k >= f);
      chk("stall", {63'd0, stall_o}, {63'd0, exp_st});
      if (!exp_st) break;
      @(negedge clk);
      k++;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    flush = 1'b0;
    if (wr) hilo_cur = d;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: every write must match the head of the scoreboard, in data and cycle.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (hilo_wen === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write cycle=%0d actual=%h expected=none", cyc, hilo_wdata);
      end else begin
        e = sb_q.pop_front();
        chk("write_cycle", 64'(cyc), 64'(e.cyc));
        chk("write_data", hilo_wdata, e.data);
      end
    end else if (hilo_wen !== 1'b0) begin
      chk("wen_known", {63'd0, hilo_wen}, 64'd0);
    end else if (sb_q.size() != 0 && sb_q[0].cyc < cyc) begin
      e = sb_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_write cycle=%0d actual=none expected=%h", cyc, e.data);
    end
  end

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    op       = '0;
    src_a    = '0;
    src_b    = '0;
    hilo_cur = '0;
    flush    = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_stall", {63'd0, stall_o}, 64'd0);
    chk("reset_wen", {63'd0, hilo_wen}, 64'd0);
    chk("reset_wdata", hilo_wdata, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("idle_stall", {63'd0, stall_o}, 64'd0);
    chk("idle_wdata", hilo_wdata, 64'd0);

    issue(4'd1, 32'hFFFF_FFFE, 32'd3, -1);
    issue(4'd3, 32'hFFFF_FFF9, 32'd2, -1);
    issue(4'd4, 32'd100, 32'd0, -1);
    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    issue(4'd3, 32'hFFFF_FFF0, 32'd0, -1);
    hilo_cur = 64'hAAAA_AAAA_BBBB_BBBB;
    issue(4'd5, 32'h1234_5678, 32'd0, -1);
    issue(4'd6, 32'hCAFE_F00D, 32'd0, -1);
    hilo_cur = 64'h1_0000_0000;
    issue(4'd8, 32'h1_0000, 32'h1_0000, -1);
    issue(4'd9, 32'hFFFF_FFFF, 32'd5, -1);
    issue(4'd3, 32'd12345, 32'd7, 10);
    issue(4'd1, 32'd7, 32'hFFFF_FFFD, -1);
    issue(4'd5, 32'h5555_5555, 32'd0, 0);
    issue(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MulLat + 1);
    issue(4'd0, 32'd1, 32'd1, -1);
    issue(4'd12, 32'd1, 32'd1, -1);

    // Reset in the middle of a divide: no write, idle afterwards.
    @(negedge clk);
    start = 1'b1;
    op    = 4'd3;
    src_a = 32'd1000;
    src_b = 32'd3;
    repeat (5) @(negedge clk);
    start = 1'b0;
    rst   = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_mid_stall", {63'd0, stall_o}, 64'd0);
    issue(4'd2, 32'd6, 32'd7, -1);

    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 3) == 0) hilo_cur = {$urandom, $urandom};
      issue(4'($urandom_range(0, 15)), pick(), pick(), -2);
      idle($urandom_range(0, 2));
    end

    idle(40);
    chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_ctrl.md
# hilo_muldiv_ctrl

Sequencer for the HI/LO register: accepts multiply, divide, multiply-accumulate and move-to-HI/LO operations from the execute stage and drives the HI/LO write port (`hilo_wen`/`hilo_wdata`). It runs a fixed-latency multiplier and a 32-iteration restoring divider. It stalls the pipeline while either is busy and supports flush on exceptions. It sits between the E stage and the HI/LO register.

## Interface
- `MUL_LAT`, default 2: multiplier latency in cycles spent in state MUL; legal range 1..8.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  valid HI/LO operation present in the E stage this cycle.
- `op`  in  4  operation code (table below).
- `src_a`  in  32  rs operand.
- `src_b`  in  32  rt operand.
- `hilo_cur`  in  64  current HI/LO register value, {HI, LO}.
- `flush`  in  1  E-stage cancel from exception or redirect.
- `stall_o`  out  1  hold the E stage and everything before it.
- `hilo_wen`  out  1  HI/LO write enable.
- `hilo_wdata`  out  64  HI/LO write data, {HI, LO}.

## Operation
- Op codes:
  - 0 NOP
  - 1 MULT, 2 MULTU, 3 DIV, 4 DIVU
  - 5 MTHI, 6 MTLO
  - 7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU
  - 11–15 are treated as NOP.
- FSM states: IDLE, MUL, DIV, DONE. A 5-bit iteration counter `cnt` tracks progress.
- IDLE:
  - `start` with MTHI → combinational `hilo_wen`=1, `hilo_wdata`={src_a, hilo_cur[31:0]}. No stall; stays in IDLE.
  - `start` with MTLO → `hilo_wdata`={hilo_cur[63:32], src_a}, handled the same way.
  - `start` with a multiply-class op → latch operands and op, `cnt`=0, go to MUL.
  - `start` with a divide op → latch operands and op, `cnt`=0, go to DIV.
  - NOP or no `start` → stay in IDLE.
- MUL:
  - Each cycle `cnt`++.
  - When `cnt`==MUL_LAT-1, go to DONE.
  - Product is 64-bit: signed for MULT/MADD/MSUB, unsigned for the U variants.
- DIV:
  - Restoring division on operand magnitudes (signed ops) or raw values (unsigned), one quotient bit per cycle.
  - When `cnt`==31, go to DONE.
- DONE:
  - `hilo_wen`=1, then return to IDLE.
  - `start` is ignored in DONE: it is the same, still-held instruction.
  - Write data per op:
    - MULT/MULTU: product.
    - MADD(U): `hilo_cur` + product.
    - MSUB(U): `hilo_cur` − product.
    - DIV/DIVU: {remainder, quotient}.
- Signed division fixup:
  - Quotient is negated when sign(a)≠sign(b); remainder takes the sign of a.
  - 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0.
- Divide by zero:
  - Quotient 0xFFFFFFFF, remainder = dividend, before sign fixup on the unsigned path.
  - Signed path: magnitude result, then fixup.
  - No exception is raised.
- `stall_o` = (IDLE & `start` & op is MUL/DIV class & !`flush`) | state∈{MUL, DIV}.
- `flush` has priority over `start` in every state:
  - Next state is IDLE.
  - `hilo_wen` is forced to 0 combinationally, including DONE and IDLE MTHI/MTLO.
  - `stall_o` is 0 that cycle.
- Arithmetic is modulo 2^64 for accumulate; overflow is ignored.

## Timing
- Reset: state IDLE, `cnt`=0, `stall_o`=0, `hilo_wen`=0, `hilo_wdata`=0, latched operands 0.
- Multiply-class op, start in cycle 0:
  - `stall_o` high in cycles 0..MUL_LAT.
  - DONE in cycle MUL_LAT+1, with `hilo_wen` high for exactly one cycle.
- Divide, start in cycle 0:
  - `stall_o` high in cycles 0..32 (33 cycles).
  - DONE in cycle 33.
- MTHI/MTLO: write is committed at the end of the start cycle, zero latency.
- `hilo_wen`/`hilo_wdata` in DONE are driven from the FSM and latched result. `hilo_cur` is sampled in DONE for MADD/MSUB.
- A new `start` is accepted in the cycle immediately after DONE.
- Reset asserted mid-operation: IDLE next cycle, no write.

## Configuration
- `HILO_MADD_EN` defined: MADD/MADDU/MSUB/MSUBU are supported as described.
- `HILO_MADD_EN` undefined:
  - Op codes 7–10 decode as NOP: no stall, no write.
  - The accumulate adder/subtractor is removed.

## Test plan
- MULT, a=0xFFFFFFFE (−2), b=3, MUL_LAT=2 → `stall_o` high 3 cycles; in cycle 3 `hilo_wen`=1, `hilo_wdata`=0xFFFFFFFF_FFFFFFFA.
- DIV, a=−7 (0xFFFFFFF9), b=2 → `stall_o` high 33 cycles; cycle 33 `hilo_wdata`={0xFFFFFFFF, 0xFFFFFFFD}.
- DIVU, a=100, b=0 → `hilo_wdata`={0x00000064, 0xFFFFFFFF}. Signed DIV 0x80000000/0xFFFFFFFF → {0, 0x80000000}.
- MTHI, a=0x12345678, `hilo_cur`=0xAAAAAAAA_BBBBBBBB → same cycle `hilo_wen`=1, `hilo_wdata`=0x12345678_BBBBBBBB, `stall_o`=0.
- MADDU, `hilo_cur`=0x1_00000000, a=b=0x10000 → DONE `hilo_wdata`=0x2_00000000. With `HILO_MADD_EN` undefined: no stall, no write.
- DIV started, `flush` in cycle 10 → `stall_o`=0 in cycle 10, IDLE in cycle 11, no `hilo_wen` ever. A new MULT accepted in cycle 11 completes normally.
